// File: rtl/spi_txn_scheduler_pkg.sv
// Shared register map, CTRL bit positions and FSM encoding for the SPI
// transaction scheduler that drives spi_top over wishbone.
package spi_sched_pkg;

  localparam logic [4:0] ADDR_TX0  = 5'h00;
  localparam logic [4:0] ADDR_CTRL = 5'h10;
  localparam logic [4:0] ADDR_DIV  = 5'h14;
  localparam logic [4:0] ADDR_SS   = 5'h18;

  localparam int CTRL_GO     = 8;
  localparam int CTRL_TX_NEG = 10;
  localparam int CTRL_ASS    = 13;

  typedef enum logic [2:0] {
    ST_INIT_DIV,
    ST_IDLE,
    ST_WR_TX,
    ST_WR_SS,
    ST_WR_CTRL,
    ST_WR_GO,
    ST_POLL,
    ST_DONE
  } state_e;

  function automatic logic [31:0] ctrl_word(input logic [6:0] len, input logic go);
    logic [31:0] w;
    w              = '0;
    w[6:0]         = len;
    w[CTRL_GO]     = go;
    w[CTRL_TX_NEG] = 1'b1;
    w[CTRL_ASS]    = 1'b1;
    return w;
  endfunction

  // Shifts of 32 or more give an all-ones mask, i.e. the whole word.
  function automatic logic [31:0] len_mask(input logic [6:0] len);
    return (32'h1 << len) - 32'h1;
  endfunction

endpackage

// File: rtl/spi_txn_scheduler_if.sv
// Wishbone master-side bus between the scheduler and spi_top.
interface spi_txn_scheduler_if;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_addr_o, wb_data_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    input  wb_data_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_addr_o, wb_data_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    output wb_data_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/spi_txn_scheduler_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping from 7 back to 0.
module rr_arbiter8 (
  input  logic [7:0] req_i,
  input  logic [2:0] ptr_i,
  output logic [7:0] grant_o,
  output logic [2:0] idx_o,
  output logic       valid_o
);

  logic [2:0] cand;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    idx_o   = ptr_i;
    valid_o = 1'b0;
    cand    = '0;
    for (int off = 7; off >= 0; off--) begin
      cand = ptr_i + 3'(off);
      if (req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

  assign grant_o = valid_o ? (8'd1 << idx_o) : 8'd0;

endmodule

// File: rtl/spi_txn_scheduler.sv
// Hardware wishbone master for spi_top: arbitrates eight single-word
// requesters and runs TX/SS/CTRL/GO/poll register sequences for each.
module spi_txn_scheduler
  import spi_sched_pkg::*;
#(
  parameter logic [15:0] C_DIVIDER     = 16'h0004,
  parameter logic [6:0]  C_RADIO_LEN   = 7'd18,
  parameter logic [6:0]  C_DAC_LEN     = 7'd16,
  parameter logic [7:0]  C_ACK_TIMEOUT = 8'd255
) (
  input  logic         OPB_Clk,
  input  logic         rst_n,
  input  logic [7:0]   req_valid,
  input  logic [255:0] req_data,
  output logic [7:0]   req_done,
  output logic         busy,
  output logic         err,
  input  logic         err_clr,
  spi_txn_scheduler_if.master wb
);

  state_e      state_q, state_d;
  logic [2:0]  target_q, target_d;
  logic [7:0]  tgt_oh_q, tgt_oh_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  rr_q, rr_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic [7:0]  arb_grant;
  logic [2:0]  arb_idx;
  logic        arb_valid;
  logic [6:0]  len;
  logic        acked, bus_err, timeout, abort, poll_busy;

  rr_arbiter8 u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign len       = target_q[2] ? C_DAC_LEN : C_RADIO_LEN;
  assign acked     = cyc_q & wb.wb_ack_i & ~wb.wb_err_i;
  assign bus_err   = cyc_q & wb.wb_err_i;
  assign timeout   = cyc_q & ~wb.wb_ack_i & ~wb.wb_err_i & (tmo_q == C_ACK_TIMEOUT - 8'd1);
  assign abort     = bus_err | timeout;
  assign poll_busy = wb.wb_data_i[CTRL_GO];

  always_ff @(posedge OPB_Clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT_DIV;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT_DIV: if (acked) state_d = ST_IDLE;
      ST_IDLE:     if (arb_valid) state_d = ST_WR_TX;
      ST_WR_TX:    if (acked) state_d = ST_WR_SS;
      ST_WR_SS:    if (acked) state_d = ST_WR_CTRL;
      ST_WR_CTRL:  if (acked) state_d = ST_WR_GO;
      ST_WR_GO:    if (acked) state_d = ST_POLL;
      ST_POLL:     if (acked && !poll_busy) state_d = ST_DONE;
      ST_DONE:     if (acked) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // A new access is launched only from a cycle where cyc is low, which
  // gives the mandatory idle cycle after every ack (and the poll re-read gap).
  always_comb begin
    target_d = target_q;
    tgt_oh_d = tgt_oh_q;
    data_d   = data_q;
    rr_d     = rr_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    tmo_d    = tmo_q;
    done_d   = '0;
    err_d    = err_q & ~err_clr;
    busy_d   = (state_d != ST_IDLE);

    if (cyc_q) begin
      if (acked || abort) begin
        cyc_d = 1'b0;
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end else if (state_q != ST_IDLE) begin
      cyc_d = 1'b1;
      tmo_d = '0;
      we_d  = 1'b1;
      case (state_q)
        ST_INIT_DIV: begin addr_d = ADDR_DIV;  wdat_d = {16'h0, C_DIVIDER}; end
        ST_WR_TX:    begin addr_d = ADDR_TX0;  wdat_d = data_q & len_mask(len); end
        ST_WR_SS:    begin addr_d = ADDR_SS;   wdat_d = {24'h0, tgt_oh_q}; end
        ST_WR_CTRL:  begin addr_d = ADDR_CTRL; wdat_d = ctrl_word(len, 1'b0); end
        ST_WR_GO:    begin addr_d = ADDR_CTRL; wdat_d = ctrl_word(len, 1'b1); end
        ST_POLL:     begin addr_d = ADDR_CTRL; wdat_d = '0; we_d = 1'b0; end
        default:     begin addr_d = ADDR_SS;   wdat_d = '0; end
      endcase
    end

    if (state_q == ST_IDLE && arb_valid) begin
      target_d = arb_idx;
      tgt_oh_d = arb_grant;
      data_d   = req_data[{arb_idx, 5'd0} +: 32];
    end

    if (state_q == ST_POLL && acked && !poll_busy) done_d = tgt_oh_q;
    if (state_q == ST_DONE && acked) rr_d = target_q + 3'd1;

    // The DONE-phase SS clear already reported completion, so no second pulse.
    if (abort) begin
      err_d = 1'b1;
      if (state_q != ST_INIT_DIV) rr_d = target_q + 3'd1;
      if (state_q != ST_INIT_DIV && state_q != ST_DONE) done_d = tgt_oh_q;
    end
  end

  always_ff @(posedge OPB_Clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      tgt_oh_q <= '0;
      data_q   <= '0;
      rr_q     <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      tmo_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      tgt_oh_q <= tgt_oh_d;
      data_q   <= data_d;
      rr_q     <= rr_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign wb.wb_cyc_o  = cyc_q;
  assign wb.wb_stb_o  = cyc_q;
  assign wb.wb_we_o   = we_q;
  assign wb.wb_addr_o = addr_q;
  assign wb.wb_data_o = wdat_q;
  assign wb.wb_sel_o  = {4{cyc_q}};
  assign req_done     = done_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed, table-driven bench for spi_txn_scheduler with a zero-wait
// wishbone slave model that can inject errors or withhold acks.
module tb_spi_txn_scheduler;

  logic         OPB_Clk = 1'b0;
  logic         rst_n;
  logic [7:0]   req_valid;
  logic [255:0] req_data;
  logic [7:0]   req_done;
  logic         busy;
  logic         err;
  logic         err_clr;

  logic         slvAck  = 1'b0;
  logic         slvErr  = 1'b0;
  logic [31:0]  slvData = '0;

  spi_txn_scheduler_if wbIf ();

  assign wbIf.wb_ack_i  = slvAck;
  assign wbIf.wb_err_i  = slvErr;
  assign wbIf.wb_data_i = slvData;

  spi_txn_scheduler dut (
    .OPB_Clk   (OPB_Clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_done  (req_done),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr),
    .wb        (wbIf)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        we;
    logic [3:0]  sel;
  } acc_t;

  typedef struct {
    logic [7:0]  reqValid;
    logic [2:0]  idx;
    logic [31:0] word;
    int          goPolls;
    logic [31:0] expTx;
    logic [31:0] expSs;
    logic [31:0] expCtrl;
    logic [31:0] expGo;
  } vec_t;

  acc_t accLog[$];
  int   doneLog[$];
  int   doneCyc[$];
  int   cycleCnt   = 0;
  int   cycRiseCyc = 0;
  logic cycPrev    = 1'b0;
  int   goPolls    = 0;
  int   pollCnt    = 0;
  bit   noAck      = 1'b0;
  bit   errArmed   = 1'b0;
  logic [4:0] errAddr = 5'h18;
  int   checkCount = 0;
  int   failCount  = 0;

  // Slave answers each access at the first negedge it sees it, so the DUT
  // samples ack on the next rising edge.
  always @(negedge OPB_Clk) begin
    cycleCnt++;
    for (int b = 0; b < 8; b++) begin
      if (req_done[b]) begin
        doneLog.push_back(b);
        doneCyc.push_back(cycleCnt);
      end
    end
    if (wbIf.wb_cyc_o && !cycPrev) cycRiseCyc = cycleCnt;
    cycPrev = wbIf.wb_cyc_o;
    slvAck  = 1'b0;
    slvErr  = 1'b0;
    slvData = '0;
    if (rst_n && wbIf.wb_cyc_o && wbIf.wb_stb_o && !noAck) begin
      if (!wbIf.wb_we_o) begin
        slvData = (pollCnt < goPolls) ? 32'h0000_2512 : 32'h0000_2412;
        pollCnt++;
      end
      accLog.push_back('{wbIf.wb_addr_o, wbIf.wb_we_o ? wbIf.wb_data_o : slvData,
                         wbIf.wb_we_o, wbIf.wb_sel_o});
      if (errArmed && wbIf.wb_we_o && wbIf.wb_addr_o == errAddr) begin
        slvErr   = 1'b1;
        errArmed = 1'b0;
      end else begin
        slvAck = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, actual, expected);
    end
  endtask

  function automatic acc_t getAcc(input int i);
    acc_t a;
    a = '{5'h1F, 32'hDEAD_BEEF, 1'b0, 4'h0};
    if (i < accLog.size()) a = accLog[i];
    return a;
  endfunction

  task automatic checkAcc(input string name, input int pos, input logic [4:0] addr,
                          input logic [31:0] data, input logic we, input bit withData);
    acc_t a;
    a = getAcc(pos);
    checkOutput({name, " addr"}, 32'(a.addr), 32'(addr));
    checkOutput({name, " we"}, 32'(a.we), 32'(we));
    if (withData) checkOutput({name, " data"}, a.data, data);
  endtask

  task automatic applyStimulus(input logic [7:0] valid, input logic [2:0] idx, input logic [31:0] word);
    @(negedge OPB_Clk);
    req_data[int'(idx) * 32 +: 32] = word;
    req_valid = valid;
  endtask

  task automatic waitDones(input string name, input int n, input int budget);
    int seen = 0;
    int k    = 0;
    while (seen < n && k < budget) begin
      @(posedge OPB_Clk);
      #1;
      seen += $countones(req_done);
      k++;
    end
    checkOutput({name, " done pulses"}, 32'(seen), 32'(n));
  endtask

  task automatic waitIdle(input string name);
    int k = 0;
    repeat (3) @(negedge OPB_Clk);
    while (busy !== 1'b0 && k < 500) begin
      @(negedge OPB_Clk);
      k++;
    end
    checkOutput({name, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic clearLogs();
    accLog.delete();
    doneLog.delete();
    doneCyc.delete();
    pollCnt = 0;
  endtask

  task automatic runVector(input vec_t v, input int n);
    string nm;
    int    nPolls;
    nm = $sformatf("vec%0d", n);
    clearLogs();
    goPolls = v.goPolls;
    applyStimulus(v.reqValid, v.idx, v.word);
    waitDones(nm, 1, 300);
    req_valid = '0;
    waitIdle(nm);
    checkOutput({nm, " done idx"}, (doneLog.size() > 0) ? doneLog[0] : 32'hFFFF_FFFF, 32'(v.idx));
    nPolls = v.goPolls + 1;
    checkOutput({nm, " access count"}, 32'(accLog.size()), 32'(4 + nPolls + 1));
    checkAcc({nm, " tx"},   0, 5'h00, v.expTx,   1'b1, 1'b1);
    checkAcc({nm, " ss"},   1, 5'h18, v.expSs,   1'b1, 1'b1);
    checkAcc({nm, " ctrl"}, 2, 5'h10, v.expCtrl, 1'b1, 1'b1);
    checkAcc({nm, " go"},   3, 5'h10, v.expGo,   1'b1, 1'b1);
    for (int p = 0; p < nPolls; p++)
      checkAcc($sformatf("%s poll%0d", nm, p), 4 + p, 5'h10, 32'h0, 1'b0, 1'b0);
    checkAcc({nm, " ss clear"}, 4 + nPolls, 5'h18, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic resetAndInit(input string name);
    rst_n     = 1'b0;
    req_valid = '0;
    err_clr   = 1'b0;
    repeat (3) @(negedge OPB_Clk);
    clearLogs();
    goPolls = 0;
    rst_n   = 1'b1;
    waitIdle(name);
    checkOutput({name, " init count"}, 32'(accLog.size()), 32'd1);
    checkAcc({name, " div"}, 0, 5'h14, 32'h0000_0004, 1'b1, 1'b1);
    checkOutput({name, " div sel"}, 32'(getAcc(0).sel), 32'hF);
    checkOutput({name, " cyc after init"}, 32'(wbIf.wb_cyc_o), 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   k;
    vecs[0] = '{8'h01, 3'd0, 32'h0003_1234, 3, 32'h0003_1234, 32'h01, 32'h2412, 32'h2512};
    vecs[1] = '{8'h10, 3'd4, 32'hABCD_5A5A, 0, 32'h0000_5A5A, 32'h10, 32'h2410, 32'h2510};
    vecs[2] = '{8'h08, 3'd3, 32'hFFFF_FFFF, 1, 32'h0003_FFFF, 32'h08, 32'h2412, 32'h2512};
    vecs[3] = '{8'h80, 3'd7, 32'h1234_0001, 2, 32'h0000_0001, 32'h80, 32'h2410, 32'h2510};
    vecs[4] = '{8'h04, 3'd2, 32'h0004_0000, 0, 32'h0000_0000, 32'h04, 32'h2412, 32'h2512};
    vecs[5] = '{8'h20, 3'd5, 32'h0001_FFFF, 0, 32'h0000_FFFF, 32'h20, 32'h2410, 32'h2510};

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    err_clr   = 1'b0;
    repeat (3) @(negedge OPB_Clk);
    checkOutput("reset cyc",  32'(wbIf.wb_cyc_o),  32'd0);
    checkOutput("reset stb",  32'(wbIf.wb_stb_o),  32'd0);
    checkOutput("reset addr", 32'(wbIf.wb_addr_o), 32'd0);
    checkOutput("reset busy", 32'(busy),           32'd0);
    checkOutput("reset err",  32'(err),            32'd0);
    checkOutput("reset done", 32'(req_done),       32'd0);

    resetAndInit("boot");

    for (int i = 0; i < 6; i++) runVector(vecs[i], i);

    // Round robin with every requester held high from pointer 0.
    resetAndInit("rr boot");
    clearLogs();
    for (int t = 0; t < 8; t++) req_data[t * 32 +: 32] = 32'h100 + t;
    @(negedge OPB_Clk);
    req_valid = 8'hFF;
    waitDones("rr", 9, 400);
    req_valid = '0;
    waitIdle("rr");
    for (int j = 0; j < 9; j++)
      checkOutput($sformatf("rr order%0d", j), (j < doneLog.size()) ? doneLog[j] : 32'hFFFF_FFFF, 32'(j % 8));

    // Bus error on the slave-select write aborts requester 1.
    clearLogs();
    errArmed = 1'b1;
    errAddr  = 5'h18;
    applyStimulus(8'h02, 3'd1, 32'h0000_00AA);
    waitDones("buserr", 1, 100);
    req_valid = '0;
    checkOutput("buserr err set", 32'(err), 32'd1);
    waitIdle("buserr");
    checkOutput("buserr cyc", 32'(wbIf.wb_cyc_o), 32'd0);
    checkOutput("buserr done idx", (doneLog.size() > 0) ? doneLog[0] : 32'hFFFF_FFFF, 32'd1);
    checkOutput("buserr access count", 32'(accLog.size()), 32'd2);
    checkAcc("buserr ss", 1, 5'h18, 32'h02, 1'b1, 1'b1);
    @(negedge OPB_Clk);
    err_clr = 1'b1;
    @(negedge OPB_Clk);
    err_clr = 1'b0;
    checkOutput("buserr err cleared", 32'(err), 32'd0);
    runVector(vecs[0], 10);
    checkOutput("after recovery err", 32'(err), 32'd0);

    // Ack timeout, with err_clr held high across the abort cycle.
    clearLogs();
    noAck   = 1'b1;
    err_clr = 1'b1;
    applyStimulus(8'h20, 3'd5, 32'h0000_1111);
    waitDones("timeout", 1, 400);
    checkOutput("timeout err beats clr", 32'(err), 32'd1);
    err_clr   = 1'b0;
    req_valid = '0;
    noAck     = 1'b0;
    @(negedge OPB_Clk);
    #1;
    checkOutput("timeout done idx", (doneLog.size() > 0) ? doneLog[0] : 32'hFFFF_FFFF, 32'd5);
    checkOutput("timeout cycles", (doneCyc.size() > 0) ? 32'(doneCyc[0] - cycRiseCyc) : 32'hFFFF_FFFF, 32'd255);
    checkOutput("timeout cyc dropped", 32'(wbIf.wb_cyc_o), 32'd0);
    waitIdle("timeout");
    checkOutput("timeout err sticky", 32'(err), 32'd1);

    // Asynchronous reset in the middle of a poll read.
    clearLogs();
    goPolls = 1000;
    applyStimulus(8'h40, 3'd6, 32'h0000_2222);
    k = 0;
    while (!(wbIf.wb_cyc_o === 1'b1 && wbIf.wb_we_o === 1'b0) && k < 100) begin
      @(negedge OPB_Clk);
      k++;
    end
    checkOutput("midpoll reached", 32'(wbIf.wb_cyc_o && !wbIf.wb_we_o), 32'd1);
    #2;
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    checkOutput("midpoll cyc", 32'(wbIf.wb_cyc_o), 32'd0);
    checkOutput("midpoll stb", 32'(wbIf.wb_stb_o), 32'd0);
    checkOutput("midpoll sel", 32'(wbIf.wb_sel_o), 32'd0);
    checkOutput("midpoll busy", 32'(busy), 32'd0);
    checkOutput("midpoll err", 32'(err), 32'd0);
    resetAndInit("midpoll reinit");

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/spi_txn_scheduler.md
Name: spi_txn_scheduler

Overview:
- Hardware master for the shared SPI controller (spi_top, wishbone slave) that serves radios 1-4 (ss[3:0]) and DACs 1-4 (ss[7:4]).
- Accepts write-word requests from eight independent requesters, one per target.
- Arbitrates requesters round-robin and runs each transaction as a wishbone register sequence: TX, SS, CTRL, GO, then poll CTRL until GO clears.
- Lets the radio/DAC init and calibration logic configure parts without software.

Parameters:
- C_DIVIDER, 16'h0004: value written once to the DIVIDER register (0x14) after reset.
- C_RADIO_LEN, 7'd18: SPI char length for targets 0-3.
- C_DAC_LEN, 7'd16: SPI char length for targets 4-7.
- C_ACK_TIMEOUT, 8'd255: cycles to wait for wb_ack_i before abort.

Ports:
- OPB_Clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  8  bit i = requester i has a word pending; held until req_done[i].
- req_data  in  256  word for requester i at [32i+31:32i]; only the low char-len bits are used.
- req_done  out  8  one-cycle pulse when requester i's transaction finishes or aborts.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  sticky; set on wb_err_i or ack timeout.
- err_clr  in  1  synchronous clear of err.
- wb_addr_o  out  5  spi_top byte address.
- wb_data_o  out  32  write data.
- wb_data_i  in  32  read data.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  wishbone strobes.
- wb_sel_o  out  4  always 4'hF during an access.
- wb_ack_i, wb_err_i  in  1 each  slave responses.

Behaviour:
- Reset: all outputs 0, RR pointer = 0, state = INIT_DIV.
- Wishbone access:
  - cyc/stb/we/addr/data are registered and held until ack or err; stb is dropped the cycle after ack.
  - At most one access is outstanding.
  - Next access starts no earlier than 1 cycle after the previous ack.
- State machine:
  - INIT_DIV: write 0x14 = C_DIVIDER, then go to IDLE. Runs only once per reset.
  - IDLE: if any req_valid, grant the lowest index at or after the RR pointer (wrapping 7 to 0), latch the target id and data, go to WR_TX. Grant decision takes 1 cycle.
  - WR_TX: write 0x00 = data masked to len bits, where len = C_RADIO_LEN for targets 0-3 and C_DAC_LEN for targets 4-7.
  - WR_SS: write 0x18 = one-hot(target) in bits [7:0].
  - WR_CTRL: write 0x10 = ASS(bit13) | TX_NEG(bit10) | len[6:0].
  - WR_GO: same value as WR_CTRL with GO(bit8) set.
  - POLL: read 0x10. If bit8 = 1, wait 1 cycle and re-read. If bit8 = 0, go to DONE.
  - DONE: pulse req_done[target], write SS = 0, set RR pointer = target+1 mod 8, go to IDLE.
- Error and timeout:
  - wb_err_i during any access, or C_ACK_TIMEOUT cycles without ack, triggers an abort.
  - Abort drops cyc/stb, sets err, pulses req_done[target] and goes to IDLE.
  - During INIT_DIV an abort sets err and goes to IDLE with no req_done pulse.
- req_valid[target] deasserting mid-transaction is ignored; the transaction completes.
- Requests arriving while busy wait for IDLE. No request is lost while valid stays high.
- err_clr and an error in the same cycle: err ends up 1.
- rst_n asserted mid-access: cyc/stb drop immediately (async). The sequence restarts at INIT_DIV after release.
- Latency, zero-wait slave acking on the cycle after stb: grant to req_done is fixed for a given poll count (measured by bench, listed in design notes).

Decomposition:
- Shared package spi_sched_pkg holds:
  - register offsets: ADDR_TX0 = 0x00, ADDR_CTRL = 0x10, ADDR_DIV = 0x14, ADDR_SS = 0x18;
  - CTRL bit positions: GO = 8, TX_NEG = 10, ASS = 13;
  - the state enumeration.
- One sub-module, rr_arbiter8: req[7:0] and pointer in, grant one-hot and index out. Purely combinational.

Test Plan:
- Reset release with no requests -> single write addr 0x14 data 0x0004, then busy = 0, wb_cyc_o = 0.
- req_valid = 8'h01, data 0x0003_1234 -> the following writes, in order:
  - 0x00 = 0x0003_1234 & 0x3FFFF;
  - 0x18 = 0x01;
  - 0x10 = 0x2412;
  - 0x10 = 0x2512.
  - Bench returns GO = 1 for 3 polls, then 0 -> req_done[0] pulses once, then SS write 0x00.
- DAC: req_valid = 8'h10, data 0xABCD_5A5A -> TX write 0x5A5A, SS 0x10, CTRL 0x2410.
- req_valid = 8'hFF held continuously -> grant order 0,1,...,7,0; each requester gets exactly one done per round.
- Slave asserts wb_err_i on the WR_SS access -> cyc drops, err = 1, req_done[i] pulses; after err_clr, err = 0 and the next request runs normally.
- Slave never acks -> after 255 cycles abort with err = 1. Separately, assert rst_n = 0 mid-POLL -> outputs 0 asynchronously, and INIT_DIV repeats after release.
